// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory bus between a fetch port and a data port.
// It issues one valid/ready bus transaction at a time and returns aligned data or an error completion to the granted port.
module mem_port_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_done,
    output logic        if_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    input  logic        d_we,
    input  logic [1:0]  d_width,
    input  logic        d_sext,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic        d_err,
    output logic        bus_valid,
    output logic [31:0] bus_addr,
    output logic        bus_we,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ready,
    input  logic [31:0] bus_rdata,
    output logic        busy,
    output logic [1:0]  state_dbg
);

    // Bus handshake: bus_valid rises with bus_addr/bus_we/bus_be/bus_wdata and all of them
    // stay constant until the first rising edge on which bus_ready=1, which both accepts the
    // transaction and delivers bus_rdata; bus_valid is low in the following cycle.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam bit               TO_EN   = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT == 0 ? 0 : TIMEOUT - 1);

    state_t           state;
    logic             last_d;
    logic             gnt_d;
    logic [1:0]       lane;
    logic [1:0]       width;
    logic             sext;
    logic             we;
    logic [CNT_W-1:0] cnt;

    logic             grant_d;
    logic [31:0]      sel_addr;
    logic [1:0]       sel_width;
    logic             sel_we;
    logic             sel_sext;
    logic             sel_bad;
    logic [3:0]       sel_be;
    logic [31:0]      sel_wdata;
    logic [7:0]       rd_byte;
    logic [15:0]      rd_half;
    logic [31:0]      rd_aligned;

    assign state_dbg = state;

    // Data wins a tie unless it was the port granted last.
    always_comb begin
        grant_d   = d_req && (!if_req || !last_d);
        sel_addr  = grant_d ? d_addr : if_addr;
        sel_width = grant_d ? d_width : 2'b10;
        sel_we    = grant_d && d_we;
        sel_sext  = grant_d && d_sext;
        sel_bad   = 1'b0;
        sel_be    = 4'hF;
        sel_wdata = 32'h0;
        case (sel_width)
            2'b00: begin
                sel_be    = 4'b0001 << sel_addr[1:0];
                sel_wdata = {4{d_wdata[7:0]}};
            end
            2'b01: begin
                sel_bad   = sel_addr[0];
                sel_be    = 4'b0011 << sel_addr[1:0];
                sel_wdata = {2{d_wdata[15:0]}};
            end
            2'b10: begin
                sel_bad   = (sel_addr[1:0] != 2'b00);
                sel_wdata = d_wdata;
            end
            default: sel_bad = 1'b1;
        endcase
        if (!sel_we) sel_wdata = 32'h0;
    end

    always_comb begin
        rd_byte = bus_rdata[7:0];
        rd_half = bus_rdata[15:0];
        case (lane)
            2'd1: begin
                rd_byte = bus_rdata[15:8];
                rd_half = bus_rdata[23:8];
            end
            2'd2: begin
                rd_byte = bus_rdata[23:16];
                rd_half = bus_rdata[31:16];
            end
            2'd3: begin
                rd_byte = bus_rdata[31:24];
                rd_half = {8'h00, bus_rdata[31:24]};
            end
            default: ;
        endcase
        case (width)
            2'b00:   rd_aligned = {{24{sext & rd_byte[7]}}, rd_byte};
            2'b01:   rd_aligned = {{16{sext & rd_half[15]}}, rd_half};
            default: rd_aligned = bus_rdata;
        endcase
        if (we) rd_aligned = 32'h0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            last_d    <= 1'b0;
            gnt_d     <= 1'b0;
            lane      <= 2'b00;
            width     <= 2'b00;
            sext      <= 1'b0;
            we        <= 1'b0;
            cnt       <= '0;
            if_rdata  <= 32'h0;
            if_done   <= 1'b0;
            if_err    <= 1'b0;
            d_rdata   <= 32'h0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            bus_valid <= 1'b0;
            bus_addr  <= 32'h0;
            bus_we    <= 1'b0;
            bus_be    <= 4'h0;
            bus_wdata <= 32'h0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (d_req || if_req) begin
                        gnt_d  <= grant_d;
                        last_d <= grant_d;
                        lane   <= sel_addr[1:0];
                        width  <= sel_width;
                        sext   <= sel_sext;
                        we     <= sel_we;
                        busy   <= 1'b1;
                        if (sel_bad) begin
                            state   <= RESP;
                            d_done  <= grant_d;
                            d_err   <= grant_d;
                            if_done <= !grant_d;
                            if_err  <= !grant_d;
                        end else begin
                            state     <= BUS;
                            cnt       <= '0;
                            bus_valid <= 1'b1;
                            bus_addr  <= {sel_addr[31:2], 2'b00};
                            bus_we    <= sel_we;
                            bus_be    <= sel_be;
                            bus_wdata <= sel_wdata;
                        end
                    end
                end
                BUS: begin
                    if (bus_ready || (TO_EN && cnt == TO_LAST)) begin
                        state     <= RESP;
                        bus_valid <= 1'b0;
                        bus_addr  <= 32'h0;
                        bus_we    <= 1'b0;
                        bus_be    <= 4'h0;
                        bus_wdata <= 32'h0;
                        d_done    <= gnt_d;
                        if_done   <= !gnt_d;
                        d_err     <= gnt_d && !bus_ready;
                        if_err    <= !gnt_d && !bus_ready;
                        if (bus_ready) begin
                            if (gnt_d) d_rdata  <= rd_aligned;
                            else       if_rdata <= bus_rdata;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    if_done  <= 1'b0;
                    if_err   <= 1'b0;
                    if_rdata <= 32'h0;
                    d_done   <= 1'b0;
                    d_err    <= 1'b0;
                    d_rdata  <= 32'h0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter, built with TIMEOUT=4 so the abort path is short.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        d_req;
    logic [31:0] d_addr;
    logic        d_we;
    logic [1:0]  d_width;
    logic        d_sext;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        d_err;
    logic        bus_valid;
    logic [31:0] bus_addr;
    logic        bus_we;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ready;
    logic [31:0] bus_rdata;
    logic        busy;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    logic [31:0] o_addr, o_wdata, o_rdata;
    logic [3:0]  o_be;
    logic        o_we, o_done, o_err;
    int          o_lat;

    mem_port_arbiter #(.TIMEOUT(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_done(if_done), .if_err(if_err),
        .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_width(d_width), .d_sext(d_sext),
        .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_err(d_err),
        .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_we(bus_we), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
        .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        if_req = 0; if_addr = 0; d_req = 0; d_addr = 0; d_we = 0;
        d_width = 0; d_sext = 0; d_wdata = 0; bus_ready = 0; bus_rdata = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset_n = 0;
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    // driver: one data transaction, ready answered in the first bus cycle
    task automatic data_txn(input logic [31:0] a, input logic w_e, input logic [1:0] w,
                            input logic sx, input logic [31:0] wd, input logic [31:0] rd,
                            output logic [31:0] r_addr, output logic [3:0] r_be, output logic r_we,
                            output logic [31:0] r_wdata, output int r_lat, output logic r_done,
                            output logic r_err, output logic [31:0] r_rdata);
        r_addr = 0; r_be = 0; r_we = 0; r_wdata = 0;
        d_req = 1; d_addr = a; d_we = w_e; d_width = w; d_sext = sx; d_wdata = wd;
        tick();
        r_lat = 1;
        if (bus_valid) begin
            r_addr = bus_addr; r_be = bus_be; r_we = bus_we; r_wdata = bus_wdata;
            bus_ready = 1; bus_rdata = rd;
            tick();
            bus_ready = 0; bus_rdata = 0;
            r_lat = 2;
        end
        r_done = d_done; r_err = d_err; r_rdata = d_rdata;
        d_req = 0;
        tick();
    endtask

    task automatic test_reset;
        idle_inputs();
        reset_n = 0;
        #1;
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL rst_bus_valid got %b exp 0", bus_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if ({d_done, if_done, d_err, if_err} !== 4'b0) begin errors++; $display("FAIL rst_done got %b exp 0000", {d_done, if_done, d_err, if_err}); end
        checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rst_state got %0d exp 0", state_dbg); end
        tick(); tick();
        reset_n = 1;
        tick();
    endtask

    task automatic test_word_load;
        d_req = 1; d_addr = 32'h100; d_we = 0; d_width = 2'b10; d_sext = 0;
        tick();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL t1_valid got %b exp 1", bus_valid); end
        checks++; if (bus_addr !== 32'h100) begin errors++; $display("FAIL t1_addr got %h exp 00000100", bus_addr); end
        checks++; if (bus_be !== 4'hF) begin errors++; $display("FAIL t1_be got %h exp f", bus_be); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy got %b exp 1", busy); end
        bus_ready = 1; bus_rdata = 32'hDEADBEEF;
        tick();
        bus_ready = 0; bus_rdata = 0;
        checks++; if (d_done !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL t1_done got d%b i%b exp d1 i0", d_done, if_done); end
        checks++; if (d_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL t1_rdata got %h exp deadbeef", d_rdata); end
        checks++; if (d_err !== 1'b0) begin errors++; $display("FAIL t1_err got %b exp 0", d_err); end
        checks++; if (bus_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_drop got %b exp 0", bus_valid); end
        d_req = 0;
        tick();
        checks++; if (d_done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t1_pulse got done%b busy%b exp 0 0", d_done, busy); end
    endtask

    task automatic test_byte_half;
        data_txn(32'h1003, 0, 2'b00, 1, 0, 32'h80FF0000, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_addr !== 32'h1000) begin errors++; $display("FAIL t2_addr got %h exp 00001000", o_addr); end
        checks++; if (o_be !== 4'b1000) begin errors++; $display("FAIL t2_be got %b exp 1000", o_be); end
        checks++; if (o_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL t2_sext got %h exp ffffff80", o_rdata); end
        data_txn(32'h1003, 0, 2'b00, 0, 0, 32'h80FF0000, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_rdata !== 32'h00000080) begin errors++; $display("FAIL t2_zext got %h exp 00000080", o_rdata); end
        data_txn(32'h2002, 0, 2'b01, 1, 0, 32'h80011234, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL t2_hbe got %b exp 1100", o_be); end
        checks++; if (o_rdata !== 32'hFFFF8001) begin errors++; $display("FAIL t2_hsext got %h exp ffff8001", o_rdata); end
        data_txn(32'h2000, 0, 2'b01, 0, 0, 32'h80019234, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_rdata !== 32'h00009234) begin errors++; $display("FAIL t2_hzext got %h exp 00009234", o_rdata); end
    endtask

    task automatic test_store;
        data_txn(32'h2002, 1, 2'b01, 0, 32'h1234ABCD, 32'h55555555, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_we !== 1'b1) begin errors++; $display("FAIL t3_we got %b exp 1", o_we); end
        checks++; if (o_be !== 4'b1100) begin errors++; $display("FAIL t3_be got %b exp 1100", o_be); end
        checks++; if (o_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL t3_wdata got %h exp abcdabcd", o_wdata); end
        checks++; if (o_done !== 1'b1 || o_rdata !== 32'h0) begin errors++; $display("FAIL t3_rdata got done%b %h exp done1 0", o_done, o_rdata); end
        data_txn(32'h1001, 1, 2'b00, 0, 32'h12345678, 32'h0, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_be !== 4'b0010 || o_wdata !== 32'h78787878) begin errors++; $display("FAIL t3_byte got be%b %h exp 0010 78787878", o_be, o_wdata); end
    endtask

    task automatic test_fetch;
        if_req = 1; if_addr = 32'h404;
        tick();
        checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h404 || bus_be !== 4'hF || bus_we !== 1'b0) begin
            errors++; $display("FAIL tf_bus got v%b %h be%h we%b exp v1 00000404 f 0", bus_valid, bus_addr, bus_be, bus_we); end
        bus_ready = 1; bus_rdata = 32'hCAFEF00D;
        tick();
        bus_ready = 0; bus_rdata = 0;
        checks++; if (if_done !== 1'b1 || d_done !== 1'b0 || if_err !== 1'b0) begin errors++; $display("FAIL tf_done got i%b d%b e%b exp 1 0 0", if_done, d_done, if_err); end
        checks++; if (if_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL tf_rdata got %h exp cafef00d", if_rdata); end
        if_req = 0;
        tick();
        if_req = 1; if_addr = 32'h402;
        tick();
        checks++; if (bus_valid !== 1'b0 || if_done !== 1'b1 || if_err !== 1'b1 || if_rdata !== 32'h0) begin
            errors++; $display("FAIL tf_misalign got v%b done%b err%b %h exp 0 1 1 0", bus_valid, if_done, if_err, if_rdata); end
        if_req = 0;
        tick();
    endtask

    task automatic test_round_robin;
        logic exp_d;
        int   n;
        do_reset();
        if_addr = 32'h400; d_addr = 32'h800; d_we = 0; d_width = 2'b10; d_sext = 0;
        if_req = 1; d_req = 1;
        for (int t = 0; t < 4; t++) begin
            exp_d = (t % 2 == 0);
            n = 0;
            do begin tick(); n++; end while (!bus_valid && n < 10);
            checks++; if (!bus_valid) begin errors++; $display("FAIL t4_timeout txn %0d got no bus_valid exp bus_valid", t); break; end
            checks++; if (bus_addr !== (exp_d ? 32'h800 : 32'h400)) begin errors++; $display("FAIL t4_order txn %0d got %h exp %h", t, bus_addr, exp_d ? 32'h800 : 32'h400); end
            bus_ready = 1; bus_rdata = 32'h1000 + t;
            tick();
            bus_ready = 0; bus_rdata = 0;
            checks++; if (d_done !== exp_d || if_done !== !exp_d) begin errors++; $display("FAIL t4_done txn %0d got d%b i%b exp d%b i%b", t, d_done, if_done, exp_d, !exp_d); end
            checks++; if ((exp_d ? d_rdata : if_rdata) !== 32'h1000 + t) begin errors++; $display("FAIL t4_rdata txn %0d got %h exp %h", t, exp_d ? d_rdata : if_rdata, 32'h1000 + t); end
            if (t == 3) begin if_req = 0; d_req = 0; end
        end
        tick(); tick();
        checks++; if (bus_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t4_idle got v%b busy%b exp 0 0", bus_valid, busy); end
    endtask

    task automatic test_timeout;
        int cnt;
        d_req = 1; d_addr = 32'h3000; d_we = 0; d_width = 2'b10; d_sext = 0;
        tick();
        cnt = 0;
        while (bus_valid && cnt < 20) begin cnt++; tick(); end
        checks++; if (cnt !== 4) begin errors++; $display("FAIL t5_valid_cycles got %0d exp 4", cnt); end
        checks++; if (d_done !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL t5_abort got done%b err%b %h exp 1 1 0", d_done, d_err, d_rdata); end
        d_req = 0;
        tick();
        data_txn(32'h3001, 0, 2'b10, 0, 0, 32'hFFFFFFFF, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_lat !== 1 || o_done !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL t5_misalign got lat%0d done%b err%b exp 1 1 1", o_lat, o_done, o_err); end
        data_txn(32'h3000, 0, 2'b11, 0, 0, 32'hFFFFFFFF, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_lat !== 1 || o_done !== 1'b1 || o_err !== 1'b1) begin errors++; $display("FAIL t5_illegal got lat%0d done%b err%b exp 1 1 1", o_lat, o_done, o_err); end
        data_txn(32'h3002, 0, 2'b01, 0, 0, 32'hA5A50000, o_addr, o_be, o_we, o_wdata, o_lat, o_done, o_err, o_rdata);
        checks++; if (o_lat !== 2 || o_err !== 1'b0 || o_rdata !== 32'h0000A5A5) begin errors++; $display("FAIL t5_half_ok got lat%0d err%b %h exp 2 0 0000a5a5", o_lat, o_err, o_rdata); end
    endtask

    task automatic test_async_reset;
        int n;
        d_req = 1; d_addr = 32'h500; d_we = 0; d_width = 2'b10;
        tick();
        checks++; if (bus_valid !== 1'b1) begin errors++; $display("FAIL t6_pre got %b exp 1", bus_valid); end
        #2;
        reset_n = 0;
        #1;
        checks++; if (bus_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL t6_async got v%b busy%b exp 0 0", bus_valid, busy); end
        idle_inputs();
        if_addr = 32'h600; d_addr = 32'h700; d_width = 2'b10;
        if_req = 1; d_req = 1;
        tick();
        reset_n = 1;
        n = 0;
        do begin tick(); n++; end while (!bus_valid && n < 10);
        checks++; if (bus_valid !== 1'b1 || bus_addr !== 32'h700) begin errors++; $display("FAIL t6_first got v%b %h exp 1 00000700", bus_valid, bus_addr); end
        bus_ready = 1; bus_rdata = 32'h77;
        tick();
        bus_ready = 0;
        if_req = 0; d_req = 0;
        checks++; if (d_done !== 1'b1 || if_done !== 1'b0) begin errors++; $display("FAIL t6_done got d%b i%b exp 1 0", d_done, if_done); end
        tick(); tick();
    endtask

    initial begin
        idle_inputs();
        reset_n = 1;
        tick();
        test_reset();
        test_word_load();
        test_byte_half();
        test_store();
        test_fetch();
        test_round_robin();
        test_timeout();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
